// File: rtl/chaos_prng_multi.sv
// Multi-channel coupled chaotic-map PRNG: logistic or tent map per channel, neighbour XOR
// coupling, seed/burn-in/run FSM with valid/ready output handshake.
module chaos_prng_multi #(
    parameter int unsigned PRECISION   = 32,
    parameter int unsigned CHANNELS    = 3,
    parameter int unsigned BURN_IN     = 16,
    parameter int unsigned MAX_SAMPLES = 0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            tvalid,
    output logic                            tready,
    input  logic [CHANNELS*PRECISION-1:0]   seeds,
    input  logic                            mode,
    input  logic                            halt,
    output logic                            valid,
    input  logic                            ready,
    output logic [CHANNELS*PRECISION-1:0]   pseudoRandomNumbers
);

    localparam int unsigned W = PRECISION;
    localparam int unsigned C = CHANNELS;
    localparam logic [31:0] BurnLoad = 32'(BURN_IN);
    localparam logic [31:0] XferLast = 32'(MAX_SAMPLES) - 32'd1;

    typedef logic [C-1:0][W-1:0] words_t;
    typedef enum logic [1:0] {StIdle, StBurn, StRun} state_e;

    state_e      state_q;
    words_t      x_q;
    words_t      x_nxt;
    words_t      seed_arr;
    words_t      seed_fix;
    logic        mode_q;
    logic [31:0] burn_cnt_q;
    logic [31:0] xfer_cnt_q;

    // One map step for a single channel, coupled to its neighbour; zero is never produced.
    function automatic logic [W-1:0] next_word(input logic [W-1:0] x, input logic [W-1:0] nb,
                                               input logic m);
        logic [2*W-1:0] p;
        logic [W-1:0]   f;
        logic [W-1:0]   v;
        p = {{W{1'b0}}, x} * {{W{1'b0}}, ~x};
        if (m) begin
            f = x[W-1] ? ((~x) << 1) : (x << 1);
        end else begin
            f = W'(p >> (W - 2));
        end
        v = f ^ (nb >> 8);
        return (v == '0) ? W'(1) : v;
    endfunction

    assign seed_arr = seeds;

    for (genvar g = 0; g < C; g++) begin : g_chan
        assign x_nxt[g]    = next_word(x_q[g], x_q[(g + 1) % C], mode_q);
        assign seed_fix[g] = (seed_arr[g] == '0) ? W'(1) : seed_arr[g];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            x_q        <= '0;
            mode_q     <= 1'b0;
            burn_cnt_q <= '0;
            xfer_cnt_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (tvalid) begin
                        x_q        <= seed_fix;
                        mode_q     <= mode;
                        burn_cnt_q <= BurnLoad;
                        xfer_cnt_q <= '0;
                        state_q    <= (BURN_IN == 0) ? StRun : StBurn;
                    end
                end
                StBurn: begin
                    if (halt) begin
                        state_q <= StIdle;
                    end else begin
                        x_q        <= x_nxt;
                        burn_cnt_q <= burn_cnt_q - 32'd1;
                        if (burn_cnt_q == 32'd1) state_q <= StRun;
                    end
                end
                StRun: begin
                    // halt wins over a simultaneous transfer
                    if (halt) begin
                        state_q <= StIdle;
                    end else if (ready) begin
                        x_q        <= x_nxt;
                        xfer_cnt_q <= xfer_cnt_q + 32'd1;
                        if (MAX_SAMPLES != 0 && xfer_cnt_q == XferLast) state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign tready              = (state_q == StIdle);
    assign valid               = (state_q == StRun);
    assign pseudoRandomNumbers = x_q;

endmodule
